// File: rtl/sequence_scan_ctrl_pkg.sv
// Shared definitions for the sequence scan controller: FSM encoding and
// the helper that sizes count/position outputs.
package sequence_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // Minimum width able to hold any value 0..n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sequence_scan_ctrl_window.sv
// PAT_W-bit sliding window over the serial stream with index-qualified
// compare, match pulse, overlapping match count and first-match position.
module pattern_window_match
   import sequence_scan_ctrl_pkg::*;
#(
   parameter int unsigned PAT_W = 3,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             bit_valid,
   input  logic             serial_bit,
   input  logic [CNT_W-1:0] bit_idx,
   input  logic [PAT_W-1:0] pattern,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             found,
   output logic [CNT_W-1:0] first_pos
);

   localparam logic [CNT_W-1:0] MinIdx = CNT_W'(PAT_W - 1);

   logic [PAT_W-1:0] win_q;
   logic [PAT_W-1:0] win_new;
   logic             hit;

   // The index guard keeps the zero-cleared window from matching early.
   assign win_new = {win_q[PAT_W-2:0], serial_bit};
   assign hit     = bit_valid && (win_new == pattern) && (bit_idx >= MinIdx);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         win_q       <= '0;
         match       <= 1'b0;
         match_count <= '0;
         found       <= 1'b0;
         first_pos   <= '0;
      end else begin
         match <= hit;
         if (bit_valid) begin
            win_q <= win_new;
         end
         if (hit) begin
            match_count <= match_count + CNT_W'(1);
            if (!found) begin
               found     <= 1'b1;
               first_pos <= bit_idx;
            end
         end
      end
   end

endmodule

// File: rtl/sequence_scan_ctrl.sv
// Serialises a captured word MSB-first and sequences an overlapping
// pattern detector over it; FSM, capture, shift register and bit counter.
module sequence_scan_ctrl
   import sequence_scan_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PAT_W  = 3,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PAT_W-1:0]  pattern,
   output logic              busy,
   output logic              done,
   output logic              serial_bit,
   output logic              bit_valid,
   output logic              match,
   output logic [CNT_W-1:0]  match_count,
   output logic              found,
   output logic [CNT_W-1:0]  first_pos
);

   if (CNT_W < cnt_width(DATA_W)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for DATA_W");
   end
   if (PAT_W < 2 || DATA_W < PAT_W) begin : g_bad_pat_w
      $error("PAT_W must be >= 2 and <= DATA_W");
   end

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

   state_e            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [PAT_W-1:0]  pat_q;
   logic [CNT_W-1:0]  bit_idx_q;
   logic              accept;

   assign accept     = (state_q == IDLE) && start;
   assign serial_bit = shift_q[DATA_W-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         pat_q     <= '0;
         bit_idx_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  shift_q   <= data_in;
                  pat_q     <= pattern;
                  bit_idx_q <= '0;
                  busy      <= 1'b1;
                  bit_valid <= 1'b1;
                  state_q   <= SCAN;
               end
            end
            SCAN: begin
               shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
               bit_idx_q <= bit_idx_q + CNT_W'(1);
               if (bit_idx_q == LastIdx) begin
                  busy      <= 1'b0;
                  bit_valid <= 1'b0;
                  done      <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               bit_valid <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   pattern_window_match #(
      .PAT_W(PAT_W),
      .CNT_W(CNT_W)
   ) u_match (
      .clock      (clock),
      .reset      (reset),
      .clear      (accept),
      .bit_valid  (bit_valid),
      .serial_bit (serial_bit),
      .bit_idx    (bit_idx_q),
      .pattern    (pat_q),
      .match      (match),
      .match_count(match_count),
      .found      (found),
      .first_pos  (first_pos)
   );

endmodule

// File: tb/tb_sequence_scan_ctrl.sv
// Bench for sequence_scan_ctrl: directed cases plus randomized scans checked
// against a reference model that evaluates every PAT_W-bit slice of the word.
module tb_sequence_scan_ctrl;

   localparam int DW = 16;
   localparam int PW = 3;
   localparam int CW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] data_in;
   logic [PW-1:0] pattern;
   logic          busy;
   logic          done;
   logic          serial_bit;
   logic          bit_valid;
   logic          match;
   logic [CW-1:0] match_count;
   logic          found;
   logic [CW-1:0] first_pos;

   int errors = 0;
   int checks = 0;

   bit exp_hit [DW];
   int exp_cnt;
   int exp_first;

   always #5 clock = ~clock;

   sequence_scan_ctrl #(
      .DATA_W(DW),
      .PAT_W (PW),
      .CNT_W (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .data_in    (data_in),
      .pattern    (pattern),
      .busy       (busy),
      .done       (done),
      .serial_bit (serial_bit),
      .bit_valid  (bit_valid),
      .match      (match),
      .match_count(match_count),
      .found      (found),
      .first_pos  (first_pos)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // A match ends at bit i when the PAT_W bits at indices i-PW+1..i equal p.
   task automatic model(input logic [DW-1:0] d, input logic [PW-1:0] p);
      logic [DW-1:0] sh;
      exp_cnt   = 0;
      exp_first = 0;
      for (int i = 0; i < DW; i++) begin
         sh = d >> (DW - 1 - i);
         exp_hit[i] = (i >= PW - 1) && (sh[PW-1:0] == p);
         if (exp_hit[i]) begin
            if (exp_cnt == 0) exp_first = i;
            exp_cnt++;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, bit_valid, 0);
      check({tag, "_match"}, match, 0);
   endtask

   // Starts a scan (caller is in IDLE), follows it bit by bit, ends in IDLE.
   task automatic run_scan(input logic [DW-1:0] d, input logic [PW-1:0] p, input bit hold,
                           input bit chg, input logic [DW-1:0] cd, input logic [PW-1:0] cp);
      int run_cnt;
      data_in = d;
      pattern = p;
      start   = 1'b1;
      model(d, p);
      tick();
      if (!hold) start = 1'b0;
      run_cnt = 0;
      for (int i = 0; i < DW; i++) begin
         if (i > 0 && exp_hit[i-1]) run_cnt++;
         check("scan_busy", busy, 1);
         check("scan_valid", bit_valid, 1);
         check("scan_done", done, 0);
         check("serial_bit", serial_bit, d[DW-1-i]);
         check("scan_match", match, (i > 0) ? exp_hit[i-1] : 1'b0);
         check("scan_count", match_count, run_cnt);
         if (chg && i == DW / 2) begin
            data_in = cd;
            pattern = cp;
         end
         tick();
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", bit_valid, 0);
      check("done_match", match, exp_hit[DW-1]);
      check("final_count", match_count, exp_cnt);
      check("final_found", found, exp_cnt > 0);
      check("final_first", first_pos, exp_first);
      tick();
      check_idle("post");
      check("held_count", match_count, exp_cnt);
      check("held_first", first_pos, exp_first);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit prev_hold;
      bit hold;
      int gap;
      reset   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      pattern = '0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_idle("rst");
         check("rst_count", match_count, 0);
         check("rst_found", found, 0);
         check("rst_first", first_pos, 0);
         check("rst_serial", serial_bit, 0);
         tick();
      end

      run_scan(16'b1010_1000_0000_0101, 3'b101, 0, 0, '0, '0);
      check("t101_count", match_count, 3);
      check("t101_found", found, 1);
      check("t101_first", first_pos, 2);

      run_scan(16'h0000, 3'b000, 0, 0, '0, '0);
      check("t000_count", match_count, 14);
      check("t000_first", first_pos, 2);

      run_scan(16'h5555, 3'b110, 0, 0, '0, '0);
      check("t110_count", match_count, 0);
      check("t110_found", found, 0);
      check("t110_first", first_pos, 0);

      // Reset in the fifth SCAN cycle aborts without a done pulse.
      data_in = 16'hFFFF;
      pattern = 3'b111;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("abort");
      check("abort_count", match_count, 0);
      check("abort_found", found, 0);
      tick();
      check_idle("abort2");
      run_scan(16'hFFFF, 3'b111, 0, 0, '0, '0);
      check("after_abort_count", match_count, 14);

      // Start held high: inputs change mid-scan, second scan follows one IDLE later.
      run_scan(16'h1234, 3'b010, 1, 1, 16'hFFFF, 3'b111);
      run_scan(16'hFFFF, 3'b111, 0, 0, '0, '0);
      check("b2b_count", match_count, 14);

      prev_hold = 1'b0;
      for (int n = 0; n < 30; n++) begin
         gap = prev_hold ? 0 : $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            check_idle("gap");
            tick();
         end
         hold = ($urandom_range(0, 3) == 0) && (n != 29);
         run_scan(DW'($urandom), PW'($urandom), hold, $urandom_range(0, 1) == 1,
                  DW'($urandom), PW'($urandom));
         prev_hold = hold;
      end

      start = 1'b0;
      tick();
      check_idle("end");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
